digit_scan_ctrl: RTL and testbench

DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

---
 rtl/digit_scan_ctrl_if.sv | 22 ++
 rtl/digit_scan_ctrl.sv | 108 ++++++++++
 tb/tb_digit_scan_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/digit_scan_ctrl_if.sv
// Digit memory write port for digit_scan_ctrl.
// The master issues one write per wr_en cycle; the slave acks one cycle later.
interface digit_scan_ctrl_if;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_ack;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        input  wr_ack
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        output wr_ack
    );
endinterface

// File: rtl/digit_scan_ctrl.sv
// 8-digit multiplexed display scan controller with per-slot guard blanking.
// Define DIGIT_SCAN_LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module digit_scan_ctrl #(
    parameter int PRESCALE = 1000,
    parameter int GUARD    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    digit_scan_ctrl_if.slave wr,
    output logic [2:0]       dig_sel,
    output logic [7:0]       dig_en,
    output logic [3:0]       dig_val,
    output logic             blank
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] G_END = CW'(GUARD - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t        state;
    logic [CW-1:0] slot_cnt;
    logic [3:0]    mem [8];
    logic [7:0]    sel_dec;
    logic [7:0]    show_en;

    assign sel_dec = 8'b1 << dig_sel;

`ifdef DIGIT_SCAN_LEADING_ZERO_BLANK_EN
    logic [7:0] lead_zero;

    // lead_zero[k]: digit k and every digit above it hold zero
    always_comb begin
        logic z;
        z         = 1'b1;
        lead_zero = '0;
        for (int k = 7; k >= 1; k--) begin
            z            = z & (mem[k] == 4'd0);
            lead_zero[k] = z;
        end
    end

    assign show_en = sel_dec & ~lead_zero;
`else
    assign show_en = sel_dec;
`endif

    assign blank = (dig_en == 8'h00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            slot_cnt  <= '0;
            dig_sel   <= '0;
            dig_en    <= '0;
            dig_val   <= '0;
            wr.wr_ack <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                mem[i] <= '0;
            end
        end else begin
            wr.wr_ack <= wr.wr_en;
            if (wr.wr_en) begin
                mem[wr.wr_addr] <= wr.wr_data;
            end
            dig_val <= mem[dig_sel];

            if (!run) begin
                state    <= IDLE;
                slot_cnt <= '0;
                dig_sel  <= '0;
                dig_en   <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        state    <= BLANK;
                        slot_cnt <= '0;
                        dig_en   <= '0;
                    end
                    BLANK: begin
                        slot_cnt <= slot_cnt + CW'(1);
                        if (slot_cnt == G_END) begin
                            state  <= SHOW;
                            dig_en <= show_en;
                        end
                    end
                    SHOW: begin
                        if (slot_cnt == LAST) begin
                            state    <= BLANK;
                            slot_cnt <= '0;
                            dig_sel  <= dig_sel + 3'd1;
                            dig_en   <= '0;
                        end else begin
                            slot_cnt <= slot_cnt + CW'(1);
                            dig_en   <= show_en;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        slot_cnt <= '0;
                        dig_en   <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl at PRESCALE=8, GUARD=2.
// Expected scan outputs come from a small slot/digit model.
module tb_digit_scan_ctrl;
    localparam int P = 8;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [2:0] dig_sel;
    logic [7:0] dig_en;
    logic [3:0] dig_val;
    logic       blank;

    digit_scan_ctrl_if wif();

    digit_scan_ctrl #(.PRESCALE(P), .GUARD(G)) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .wr      (wif),
        .dig_sel (dig_sel),
        .dig_en  (dig_en),
        .dig_val (dig_val),
        .blank   (blank)
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_pass = 0;
    int         n      = 0;
    logic [3:0] exp_mem [8];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_en(input int k);
        int         ph;
        int         d;
        logic [7:0] e;
        ph = k % P;
        d  = (k / P) % 8;
        e  = (ph >= G) ? 8'(1 << d) : 8'h00;
`ifdef DIGIT_SCAN_LEADING_ZERO_BLANK_EN
        if (d >= 1) begin
            bit z;
            z = 1'b1;
            for (int j = d; j < 8; j++) begin
                if (exp_mem[j] != 4'd0) z = 1'b0;
            end
            if (z) e = 8'h00;
        end
`endif
        return e;
    endfunction

    // n counts edges since scanning started; edge 0 enters the first blank
    task automatic scan(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            int       d;
            bit [7:0] e;
            tick();
            d = (n / P) % 8;
            e = exp_en(n);
            check("scan_en", 32'(dig_en), 32'(e));
            check("scan_blank", 32'(blank), 32'(e == 8'h00));
            check("scan_sel", 32'(dig_sel), 32'(d));
            if (n % P >= 1)
                check("scan_val", 32'(dig_val), 32'(exp_mem[d]));
            n++;
        end
    endtask

    task automatic wr_one(input logic [2:0] a, input logic [3:0] v);
        wif.wr_en   = 1'b1;
        wif.wr_addr = a;
        wif.wr_data = v;
        tick();
        exp_mem[a] = v;
        check("wr_ack", 32'(wif.wr_ack), 32'd1);
    endtask

    initial begin
        wif.wr_en   = 1'b0;
        wif.wr_addr = '0;
        wif.wr_data = '0;
        for (int i = 0; i < 8; i++) exp_mem[i] = 4'd0;

        tick();
        rst = 1'b0;
        check("rst_en", 32'(dig_en), 32'h0);
        check("rst_sel", 32'(dig_sel), 32'h0);
        check("rst_val", 32'(dig_val), 32'h0);
        check("rst_blank", 32'(blank), 32'h1);
        check("rst_ack", 32'(wif.wr_ack), 32'h0);

        wr_one(3'd3, 4'h9);
        wr_one(3'd5, 4'h2);
        wr_one(3'd6, 4'h6);
        wif.wr_en = 1'b0;
        tick();
        check("ack_drop", 32'(wif.wr_ack), 32'h0);
        check("idle_en", 32'(dig_en), 32'h0);

        run = 1'b1;
        n   = 0;
        scan(44);

        wif.wr_en   = 1'b1;
        wif.wr_addr = 3'd5;
        wif.wr_data = 4'hA;
        tick();
        wif.wr_en = 1'b0;
        check("show_wr_ack", 32'(wif.wr_ack), 32'h1);
        check("show_wr_en", 32'(dig_en), 32'h20);
        exp_mem[5] = 4'hA;
        n = 45;
        scan(7);

        run = 1'b0;
        tick();
        check("stop_en", 32'(dig_en), 32'h0);
        check("stop_blank", 32'(blank), 32'h1);
        check("stop_sel", 32'(dig_sel), 32'h0);
        tick();
        check("stop_idle_en", 32'(dig_en), 32'h0);
        run = 1'b1;
        n   = 0;
        scan(12);

        rst         = 1'b1;
        wif.wr_en   = 1'b1;
        wif.wr_addr = 3'd1;
        wif.wr_data = 4'h7;
        tick();
        rst       = 1'b0;
        wif.wr_en = 1'b0;
        check("mrst_en", 32'(dig_en), 32'h0);
        check("mrst_sel", 32'(dig_sel), 32'h0);
        check("mrst_val", 32'(dig_val), 32'h0);
        check("mrst_blank", 32'(blank), 32'h1);
        check("mrst_ack", 32'(wif.wr_ack), 32'h0);
        for (int i = 0; i < 8; i++) exp_mem[i] = 4'd0;
        n = 0;
        scan(64);

        run = 1'b0;
        tick();
        check("stop2_en", 32'(dig_en), 32'h0);
        wr_one(3'd0, 4'h3);
        wr_one(3'd1, 4'h2);
        wr_one(3'd2, 4'h1);
        wif.wr_en = 1'b0;
        run = 1'b1;
        n   = 0;
        scan(66);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
